// File: rtl/dc_pkg.sv
// Shared definitions for the DC SPI path.
// Holds the default DAC count and frame length, the 32-bit frame word type
// and the writer state encoding. Imported by the upstream dispatcher and by
// the SPI writer.
package dc_pkg;

  localparam int DAC_CHANNEL = 24;
  localparam int FRAME_WORDS = 62;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    WORD_GAP,
    DONE
  } wr_state_e;

endpackage

// File: rtl/dc_spi_writer_if.sv
// Frame hand-off bus between the upstream dispatcher and dc_spi_writer.
// Signals (direction seen from the writer):
//   i_dc_regs      FRAME_WORDS x 32  frame words, word 0 is the header
//   i_channel_sel  5                 target DAC index
//   i_valid_frame  1                 one-cycle frame strobe
//   o_busy         1                 transfer in progress
//   o_done         1                 one-cycle frame-complete pulse
//   o_frame_drop   1                 one-cycle pulse, frame rejected while busy
//   o_err_channel  1                 one-cycle pulse, channel out of range
// master = dispatcher side, slave = writer side.
interface dc_spi_writer_if #(
  parameter int FRAME_WORDS = dc_pkg::FRAME_WORDS
);

  dc_pkg::word_t [FRAME_WORDS-1:0] i_dc_regs;
  logic [4:0]                      i_channel_sel;
  logic                            i_valid_frame;
  logic                            o_busy;
  logic                            o_done;
  logic                            o_frame_drop;
  logic                            o_err_channel;

  modport master (
    output i_dc_regs, i_channel_sel, i_valid_frame,
    input  o_busy, o_done, o_frame_drop, o_err_channel
  );

  modport slave (
    input  i_dc_regs, i_channel_sel, i_valid_frame,
    output o_busy, o_done, o_frame_drop, o_err_channel
  );

endinterface

// File: rtl/dc_spi_shifter.sv
// One 32-bit SPI mode-0 word transfer, MSB first.
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   load_i        latch word_i and present its bit 31 on mosi_o
//   word_i        word to send
//   start_i       begin the 32 clock periods (shifter must be idle)
//   sclk_o        SPI clock, idles low; low CLK_DIV then high CLK_DIV per bit
//   mosi_o        SPI data, updated only on the falling SCLK edge
//   done_o        high in the final cycle of the last high phase
module dc_spi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        start_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        done_o
);

  localparam int PC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [31:0]     sreg_q;
  logic            active_q;
  logic            sclk_q;
  logic            mosi_q;
  logic [PC_W-1:0] pc_q;
  logic [4:0]      bit_q;
  logic            phase_end;

  assign phase_end = (pc_q == PC_W'(CLK_DIV - 1));
  // Combinational so the writer leaves SHIFT on the same edge SCLK drops.
  assign done_o    = active_q && sclk_q && phase_end && (bit_q == 5'd31);
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      pc_q     <= '0;
      bit_q    <= '0;
    end else begin
      if (load_i) begin
        mosi_q <= word_i[31];
      end
      if (start_i) begin
        active_q <= 1'b1;
        sclk_q   <= 1'b0;
        pc_q     <= '0;
        bit_q    <= '0;
      end else if (active_q) begin
        if (phase_end) begin
          pc_q <= '0;
          if (!sclk_q) begin
            sclk_q <= 1'b1;
          end else begin
            sclk_q <= 1'b0;
            if (bit_q == 5'd31) begin
              active_q <= 1'b0;
              mosi_q   <= 1'b0;
              bit_q    <= '0;
            end else begin
              bit_q  <= bit_q + 5'd1;
              mosi_q <= sreg_q[30];
            end
          end
        end else begin
          pc_q <= pc_q + PC_W'(1);
        end
      end
    end
  end

  // Data shift register, not reset; advances on each falling SCLK edge.
  always_ff @(posedge i_clk) begin
    if (load_i) begin
      sreg_q <= word_i;
    end else if (active_q && phase_end && sclk_q) begin
      sreg_q <= {sreg_q[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/dc_spi_writer.sv
// Frame sequencer for the DC DAC SPI chain.
// Accepts a frame from the dispatcher, buffers it and sends words
// 1..FRAME_WORDS-1 to one DAC, each framed by its own chip-select window.
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   bus           dc_spi_writer_if.slave frame hand-off and status pulses
//   o_sclk        SPI clock (mode 0)
//   o_mosi        SPI data, MSB first
//   o_cs_n        per-DAC active-low chip-selects, at most one low
module dc_spi_writer #(
  parameter int DAC_CHANNEL = dc_pkg::DAC_CHANNEL,
  parameter int FRAME_WORDS = dc_pkg::FRAME_WORDS,
  parameter int CLK_DIV     = 4,
  parameter int CS_GAP      = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  dc_spi_writer_if.slave         bus,
  output logic                   o_sclk,
  output logic                   o_mosi,
  output logic [DAC_CHANNEL-1:0] o_cs_n
);

  import dc_pkg::*;

  localparam int WORD_W  = $clog2(FRAME_WORDS);
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  wr_state_e               state_q;
  logic [DAC_CHANNEL-1:0]  cs_n_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    drop_q;
  logic                    err_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WORD_W-1:0]       word_q;
  logic [4:0]              chan_q;
  word_t [FRAME_WORDS-1:0] payload_q;

  logic              idle_like;
  logic              chan_ok;
  logic              accept;
  logic              setup_end;
  logic              hold_end;
  logic              gap_end;
  logic              last_word;
  logic [WORD_W-1:0] next_word;
  logic              sh_load;
  word_t             sh_word;
  logic              sh_done;

  function automatic logic [DAC_CHANNEL-1:0] cs_mask(input logic [4:0] ch);
    cs_mask = ~({{(DAC_CHANNEL-1){1'b0}}, 1'b1} << ch);
  endfunction

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign chan_ok   = ({27'd0, bus.i_channel_sel} < 32'(DAC_CHANNEL));
  assign accept    = bus.i_valid_frame && idle_like && chan_ok;
  assign setup_end = (state_q == CS_SETUP) && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign hold_end  = (state_q == CS_HOLD)  && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign gap_end   = (state_q == WORD_GAP) && (cnt_q == CNT_W'(CS_GAP - 1));
  assign last_word = (word_q == WORD_W'(FRAME_WORDS - 1));
  assign next_word = word_q + WORD_W'(1);

  // Word 1 comes straight off the bus on acceptance since the buffer is
  // only written on that same edge; later words come from the buffer.
  assign sh_load = accept || (gap_end && !last_word);
  assign sh_word = accept ? bus.i_dc_regs[1] : payload_q[next_word];

  dc_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load_i  (sh_load),
    .word_i  (sh_word),
    .start_i (setup_end),
    .sclk_o  (o_sclk),
    .mosi_o  (o_mosi),
    .done_o  (sh_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cs_n_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
      chan_q  <= '0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.i_valid_frame) begin
            if (chan_ok) begin
              state_q <= CS_SETUP;
              chan_q  <= bus.i_channel_sel;
              cs_n_q  <= cs_mask(bus.i_channel_sel);
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              word_q  <= WORD_W'(1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CS_SETUP: begin
          if (setup_end) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (sh_done) begin
            state_q <= CS_HOLD;
            cnt_q   <= '0;
          end
        end
        CS_HOLD: begin
          if (hold_end) begin
            state_q <= WORD_GAP;
            cs_n_q  <= '1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WORD_GAP: begin
          if (gap_end) begin
            cnt_q <= '0;
            if (last_word) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              word_q  <= '0;
            end else begin
              state_q <= CS_SETUP;
              word_q  <= next_word;
              cs_n_q  <= cs_mask(chan_q);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (bus.i_valid_frame && !idle_like) begin
        drop_q <= 1'b1;
      end
    end
  end

  // Payload buffer, not reset; the header slot is stored but never sent.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      payload_q <= bus.i_dc_regs;
    end
  end

  assign o_cs_n            = cs_n_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_frame_drop  = drop_q;
  assign bus.o_err_channel = err_q;

endmodule

// File: tb/tb_dc_spi_writer.sv
module tb_dc_spi_writer;
  import dc_pkg::*;

  localparam int NW  = FRAME_WORDS;
  localparam int NTX = NW - 1;
  localparam logic [DAC_CHANNEL-1:0] CS_IDLE = '1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dc_spi_writer_if #(.FRAME_WORDS(NW)) bus  ();
  dc_spi_writer_if #(.FRAME_WORDS(NW)) bus2 ();

  logic sclk, mosi, sclk2, mosi2;
  logic [DAC_CHANNEL-1:0] cs_n, cs_n2;

  dc_spi_writer #(.DAC_CHANNEL(DAC_CHANNEL), .FRAME_WORDS(NW), .CLK_DIV(4), .CS_GAP(8)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n));

  dc_spi_writer #(.DAC_CHANNEL(DAC_CHANNEL), .FRAME_WORDS(NW), .CLK_DIV(1), .CS_GAP(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .bus(bus2), .o_sclk(sclk2), .o_mosi(mosi2), .o_cs_n(cs_n2));

  int nvec = 0;
  int nmis = 0;

  function automatic logic [DAC_CHANNEL-1:0] onehot_n(input int ch);
    onehot_n = ~({{(DAC_CHANNEL-1){1'b0}}, 1'b1} << ch);
  endfunction

  function automatic word_t pat(input int f, input int k);
    case (f)
      0:       pat = 32'hA500_0000 + 32'(k);
      1:       pat = 32'h5A5A_0000 + 32'(k);
      2:       pat = 32'hC300_0000 + (32'(k) << 8);
      3:       pat = 32'h1234_5678 ^ (32'(k) * 32'h0101_0101);
      5:       pat = (k % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      default: pat = 32'hDEAD_0000 + 32'(k);
    endcase
  endfunction

  // Mode-0 monitors: sample MOSI on each SCLK rise while a CS is low.
  word_t rxq[$];
  word_t rxq2[$];
  int    fall2[$];
  word_t shreg = '0, shreg2 = '0;
  int    bitcnt = 0, bitcnt2 = 0;
  logic  sclk_prev = 1'b0, sclk_prev2 = 1'b0, cs_idle_prev2 = 1'b1;
  int    exp_ch = 0, exp_ch2 = 0;
  int    cs_bad = 0, cs_bad2 = 0;

  always @(negedge clk) begin
    sclk_prev <= sclk;
    if (&cs_n) begin
      bitcnt <= 0;
    end else if (sclk && !sclk_prev) begin
      if (bitcnt == 31) begin
        rxq.push_back({shreg[30:0], mosi});
        bitcnt <= 0;
      end else begin
        bitcnt <= bitcnt + 1;
      end
      shreg <= {shreg[30:0], mosi};
    end
    if (!(&cs_n) && (cs_n != onehot_n(exp_ch))) cs_bad <= cs_bad + 1;
  end

  always @(negedge clk) begin
    sclk_prev2    <= sclk2;
    cs_idle_prev2 <= &cs_n2;
    if (!(&cs_n2) && cs_idle_prev2) fall2.push_back(cyc);
    if (&cs_n2) begin
      bitcnt2 <= 0;
    end else if (sclk2 && !sclk_prev2) begin
      if (bitcnt2 == 31) begin
        rxq2.push_back({shreg2[30:0], mosi2});
        bitcnt2 <= 0;
      end else begin
        bitcnt2 <= bitcnt2 + 1;
      end
      shreg2 <= {shreg2[30:0], mosi2};
    end
    if (!(&cs_n2) && (cs_n2 != onehot_n(exp_ch2))) cs_bad2 <= cs_bad2 + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp);
    nvec++;
    if (act < exp - 1 || act > exp + 1) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d +/- 1", name, act, exp);
    end
  endtask

  task automatic fill(input int which, input int f);
    for (int k = 0; k < NW; k++) begin
      if (which == 1) bus.i_dc_regs[k] = pat(f, k);
      else            bus2.i_dc_regs[k] = pat(f, k);
    end
  endtask

  task automatic wait_done(input int which, input int budget, output bit found, output int at);
    found = 1'b0;
    at = 0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (which == 1) found = (bus.o_done === 1'b1);
      else            found = (bus2.o_done === 1'b1);
      at = cyc;
    end
  endtask

  task automatic check_rx(input string tag, input int which, input int f, input int count);
    word_t got;
    for (int k = 1; k <= count; k++) begin
      got = 'x;
      if (which == 1 && (k - 1) < rxq.size())  got = rxq[k-1];
      if (which == 2 && (k - 1) < rxq2.size()) got = rxq2[k-1];
      check($sformatf("%s_word%0d", tag, k), got, pat(f, k));
    end
  endtask

  typedef struct {
    logic [4:0] chan;
    logic       exp_err;
    logic       exp_busy;
  } chvec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    chvec_t tbl[4];
    bit found;
    int t_fall, t_done;

    tbl[0] = '{5'd24, 1'b1, 1'b0};
    tbl[1] = '{5'd25, 1'b1, 1'b0};
    tbl[2] = '{5'd30, 1'b1, 1'b0};
    tbl[3] = '{5'd31, 1'b1, 1'b0};

    rst = 1'b1;
    bus.i_valid_frame  = 1'b0;
    bus.i_channel_sel  = '0;
    bus2.i_valid_frame = 1'b0;
    bus2.i_channel_sel = '0;
    fill(1, 4);
    fill(2, 4);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs_n", cs_n, CS_IDLE);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_drop", bus.o_frame_drop, 0);
    check("rst_err", bus.o_err_channel, 0);
    check("rst_cs_n2", cs_n2, CS_IDLE);
    check("rst_busy2", bus2.o_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Illegal channel vectors
    for (int i = 0; i < 4; i++) begin
      bus.i_channel_sel = tbl[i].chan;
      bus.i_valid_frame = 1'b1;
      @(negedge clk);
      bus.i_valid_frame = 1'b0;
      check($sformatf("badch%0d_err", tbl[i].chan), bus.o_err_channel, tbl[i].exp_err);
      check($sformatf("badch%0d_busy", tbl[i].chan), bus.o_busy, tbl[i].exp_busy);
      check($sformatf("badch%0d_cs", tbl[i].chan), cs_n, CS_IDLE);
      check($sformatf("badch%0d_drop", tbl[i].chan), bus.o_frame_drop, 0);
      @(negedge clk);
      check($sformatf("badch%0d_err_pulse", tbl[i].chan), bus.o_err_channel, 0);
      check($sformatf("badch%0d_busy2", tbl[i].chan), bus.o_busy, 0);
      check($sformatf("badch%0d_cs2", tbl[i].chan), cs_n, CS_IDLE);
    end

    // Frame A on channel 3, with an overlapping frame that must be dropped
    fill(1, 0);
    exp_ch = 3;
    rxq.delete();
    bus.i_channel_sel = 5'd3;
    bus.i_valid_frame = 1'b1;
    @(negedge clk);
    bus.i_valid_frame = 1'b0;
    fill(1, 4);
    check("A_cs_fall", cs_n, onehot_n(3));
    check("A_busy", bus.o_busy, 1);
    t_fall = cyc;
    repeat (99) @(negedge clk);
    fill(1, 1);
    bus.i_channel_sel = 5'd7;
    bus.i_valid_frame = 1'b1;
    @(negedge clk);
    bus.i_valid_frame = 1'b0;
    fill(1, 4);
    check("A_drop_pulse", bus.o_frame_drop, 1);
    check("A_cs_during_drop", cs_n, onehot_n(3));
    @(negedge clk);
    check("A_drop_once", bus.o_frame_drop, 0);
    wait_done(1, 20000, found, t_done);
    check("A_done_seen", found, 1);
    check_tol("A_done_latency", t_done - t_fall, NTX * 272);
    check("A_busy_in_done", bus.o_busy, 0);

    // Frame C offered in the done cycle
    fill(1, 2);
    exp_ch = 5;
    bus.i_channel_sel = 5'd5;
    bus.i_valid_frame = 1'b1;
    check("A_rx_count", rxq.size(), NTX);
    check_rx("A", 1, 0, NTX);
    check("A_cs_other_bits", cs_bad, 0);
    rxq.delete();
    @(negedge clk);
    bus.i_valid_frame = 1'b0;
    fill(1, 4);
    check("C_cs_fall_after_done", cs_n, onehot_n(5));
    check("C_no_drop", bus.o_frame_drop, 0);
    check("C_busy", bus.o_busy, 1);
    check("C_done_once", bus.o_done, 0);

    // Reset in the high phase of bit 17 of word 5
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      found = (rxq.size() == 4 && bitcnt == 18);
    end
    check("C_reach_w5b17", found, 1);
    check_rx("C", 1, 2, 4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", cs_n, CS_IDLE);
    check("midrst_sclk", sclk, 0);
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_mosi", mosi, 0);
    check("midrst_done", bus.o_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fresh frame D on the highest legal channel
    fill(1, 3);
    exp_ch = 23;
    rxq.delete();
    bus.i_channel_sel = 5'd23;
    bus.i_valid_frame = 1'b1;
    @(negedge clk);
    bus.i_valid_frame = 1'b0;
    fill(1, 4);
    check("D_cs_fall", cs_n, onehot_n(23));
    t_fall = cyc;
    wait_done(1, 20000, found, t_done);
    check("D_done_seen", found, 1);
    check_tol("D_done_latency", t_done - t_fall, NTX * 272);
    check("D_rx_count", rxq.size(), NTX);
    check_rx("D", 1, 3, NTX);
    @(negedge clk);
    check("D_done_once", bus.o_done, 0);
    check("D_idle_cs", cs_n, CS_IDLE);
    check("D_cs_other_bits", cs_bad, 0);

    // Fast instance: CLK_DIV=1, CS_GAP=1, alternating patterns
    fill(2, 5);
    exp_ch2 = 0;
    bus2.i_channel_sel = 5'd0;
    bus2.i_valid_frame = 1'b1;
    @(negedge clk);
    bus2.i_valid_frame = 1'b0;
    fill(2, 4);
    check("F_cs_fall", cs_n2, onehot_n(0));
    t_fall = cyc;
    wait_done(2, 6000, found, t_done);
    check("F_done_seen", found, 1);
    check_tol("F_done_latency", t_done - t_fall, NTX * 67);
    check("F_rx_count", rxq2.size(), NTX);
    check_rx("F", 2, 5, NTX);
    check("F_fall_count", fall2.size(), NTX);
    for (int i = 1; i < NTX && i < fall2.size(); i++)
      check($sformatf("F_word_period%0d", i), fall2[i] - fall2[i-1], 67);
    check("F_cs_other_bits", cs_bad2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
